// File: rtl/grf_writeback_sink.sv
// General register file at the receiving end of the write-back path.
// Two combinational read ports with write-first bypass, plus a last-write echo and write counter for trace.
module grf_writeback_sink #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          WE,
  input  logic [AW-1:0] WA,
  input  logic [DW-1:0] WD,
  input  logic [AW-1:0] A1,
  input  logic [AW-1:0] A2,
  output logic [DW-1:0] RD1,
  output logic [DW-1:0] RD2,
  output logic          lw_valid,
  output logic [AW-1:0] lw_addr,
  output logic [DW-1:0] lw_data,
  output logic [CW-1:0] wr_count
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] regs [0:DEPTH-1];
  logic          eff_write;

  // Writes to register 0 are discarded, so it stays zero forever.
  assign eff_write = WE && (WA != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (eff_write) begin
      regs[WA] <= WD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lw_valid <= 1'b0;
      lw_addr  <= '0;
      lw_data  <= '0;
      wr_count <= '0;
    end else begin
      lw_valid <= eff_write;
      if (eff_write) begin
        lw_addr  <= WA;
        lw_data  <= WD;
        wr_count <= wr_count + CW'(1);
      end
    end
  end

  // Write-first: an in-flight write to the addressed register wins over storage.
  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (A1 != '0) begin
      RD1 = (WE && (WA == A1)) ? WD : regs[A1];
    end
    if (A2 != '0) begin
      RD2 = (WE && (WA == A2)) ? WD : regs[A2];
    end
  end

endmodule

// File: tb/tb_grf_writeback_sink.sv
// Randomised and directed checks of grf_writeback_sink against an array-based reference model.
// A second instance with a 4-bit counter shares the inputs to exercise counter wrap.
module tb_grf_writeback_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE;
  logic [4:0]  WA, A1, A2;
  logic [31:0] WD;
  logic [31:0] RD1, RD2, lw_data, wr_count;
  logic        lw_valid;
  logic [4:0]  lw_addr;
  logic [31:0] s_RD1, s_RD2, s_lw_data;
  logic        s_lw_valid;
  logic [4:0]  s_lw_addr;
  logic [3:0]  s_wr_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mdl [32];
  logic [31:0] m_cnt;
  logic        m_valid;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  grf_writeback_sink dut (
    .clk(clk), .reset(reset), .WE(WE), .WA(WA), .WD(WD), .A1(A1), .A2(A2),
    .RD1(RD1), .RD2(RD2), .lw_valid(lw_valid), .lw_addr(lw_addr),
    .lw_data(lw_data), .wr_count(wr_count)
  );

  grf_writeback_sink #(.DW(32), .AW(5), .CW(4)) dut4 (
    .clk(clk), .reset(reset), .WE(WE), .WA(WA), .WD(WD), .A1(A1), .A2(A2),
    .RD1(s_RD1), .RD2(s_RD2), .lw_valid(s_lw_valid), .lw_addr(s_lw_addr),
    .lw_data(s_lw_data), .wr_count(s_wr_count)
  );

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (WE === 1'b1 && WA == a) return WD;
    return mdl[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    m_cnt = 0; m_valid = 0; m_addr = 0; m_data = 0;
  endtask

  // One rising edge; the model follows the write rule, then outputs settle for checking.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      if (WE && WA != 0) begin
        mdl[WA] = WD; m_cnt = m_cnt + 1; m_valid = 1; m_addr = WA; m_data = WD;
      end else begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2);
    WE = we; WA = wa; WD = wd; A1 = a1; A2 = a2;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; drive(0, 0, 0, 0, 0); model_clear();
    #12 reset = 1'b0;
    @(negedge clk);
    drive(1, 5, 32'h1234, 5, 0);
    tick();
    drive(0, 0, 0, 5, 0);
    n_cmp++; if (RD1 !== 32'h1234) begin n_bad++; $display("[TB] FAIL pre_reset_rd1 got %h want %h", RD1, 32'h1234); end
    #2 reset = 1'b1; model_clear(); #1;
    n_cmp++; if (RD1 !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_rd1 got %h want 0", RD1); end
    n_cmp++; if (wr_count !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_count got %0d want 0", wr_count); end
    n_cmp++; if (lw_valid !== 1'b0 || lw_addr !== 5'd0 || lw_data !== 32'h0) begin
      n_bad++; $display("[TB] FAIL reset_echo got v%b a%0d d%h want all 0", lw_valid, lw_addr, lw_data);
    end
    // Edges while reset is held must not write, though bypass still shows WD.
    drive(1, 7, 32'hCAFE0007, 7, 0);
    n_cmp++; if (RD1 !== 32'hCAFE0007) begin n_bad++; $display("[TB] FAIL reset_bypass got %h want %h", RD1, 32'hCAFE0007); end
    tick();
    @(negedge clk); reset = 1'b0;
    drive(0, 0, 0, 7, 0);
    n_cmp++; if (RD1 !== 32'h0 || wr_count !== 32'h0) begin
      n_bad++; $display("[TB] FAIL reset_nowrite got rd1 %h cnt %0d want 0 0", RD1, wr_count);
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    drive(1, 8, 32'hDEADBEEF, 0, 0);
    tick();
    drive(0, 0, 0, 8, 0);
    n_cmp++; if (RD1 !== 32'hDEADBEEF) begin n_bad++; $display("[TB] FAIL basic_rd1 got %h want DEADBEEF", RD1); end
    n_cmp++; if (lw_valid !== 1'b1 || lw_addr !== 5'd8 || lw_data !== 32'hDEADBEEF) begin
      n_bad++; $display("[TB] FAIL basic_echo got v%b a%0d d%h want v1 a8 dDEADBEEF", lw_valid, lw_addr, lw_data);
    end
    n_cmp++; if (wr_count !== 32'd1) begin n_bad++; $display("[TB] FAIL basic_count got %0d want 1", wr_count); end
    tick();
    n_cmp++; if (lw_valid !== 1'b0 || lw_addr !== 5'd8) begin
      n_bad++; $display("[TB] FAIL basic_pulse got v%b a%0d want v0 a8", lw_valid, lw_addr);
    end
  endtask

  task automatic test_reg0();
    logic [31:0] c0;
    c0 = m_cnt;
    @(negedge clk);
    drive(1, 0, 32'hFFFFFFFF, 0, 0);
    n_cmp++; if (RD1 !== 32'h0) begin n_bad++; $display("[TB] FAIL reg0_pre got %h want 0", RD1); end
    tick();
    drive(0, 0, 0, 0, 0);
    n_cmp++; if (RD1 !== 32'h0 || wr_count !== c0 || lw_valid !== 1'b0) begin
      n_bad++; $display("[TB] FAIL reg0_post got rd1 %h cnt %0d v%b want 0 %0d 0", RD1, wr_count, lw_valid, c0);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    drive(1, 3, 32'h11, 0, 0);
    tick();
    drive(1, 3, 32'h22, 3, 3);
    n_cmp++; if (RD1 !== 32'h22 || RD2 !== 32'h22) begin
      n_bad++; $display("[TB] FAIL bypass_pre got %h %h want 22 22", RD1, RD2);
    end
    tick();
    drive(0, 0, 0, 3, 3);
    n_cmp++; if (RD1 !== 32'h22 || RD2 !== 32'h22) begin
      n_bad++; $display("[TB] FAIL bypass_post got %h %h want 22 22", RD1, RD2);
    end
  endtask

  task automatic test_link();
    @(negedge clk);
    drive(1, 31, 32'h00003008, 0, 31);
    n_cmp++; if (RD2 !== 32'h00003008) begin n_bad++; $display("[TB] FAIL link_rd2 got %h want 00003008", RD2); end
    tick();
    drive(0, 0, 0, 0, 31);
    n_cmp++; if (RD2 !== 32'h00003008 || lw_addr !== 5'd31) begin
      n_bad++; $display("[TB] FAIL link_post got rd2 %h addr %0d want 00003008 31", RD2, lw_addr);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk); reset = 1'b1; model_clear(); drive(0, 0, 0, 0, 0);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(1, (i % 2 == 0) ? 5'd1 : 5'd2, $urandom, 0, 0);
      tick();
      @(negedge clk);
      drive(1, 0, $urandom, 0, 0);
      tick();
    end
    n_cmp++; if (s_wr_count !== 4'd1) begin n_bad++; $display("[TB] FAIL wrap_cw4 got %0d want 1", s_wr_count); end
    n_cmp++; if (wr_count !== 32'd17) begin n_bad++; $display("[TB] FAIL wrap_cw32 got %0d want 17", wr_count); end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7) == 0 ? 0 : $urandom),
            $urandom, 5'($urandom), 5'($urandom));
      if ($urandom_range(0, 3) == 0) begin A1 = WA; #1; end
      if ($urandom_range(0, 3) == 0) begin A2 = WA; #1; end
      e1 = mread(A1); e2 = mread(A2);
      n_cmp++; if (RD1 !== e1 || RD2 !== e2) begin
        n_bad++; $display("[TB] FAIL rand_read[%0d] got %h %h want %h %h", i, RD1, RD2, e1, e2);
      end
      tick();
      n_cmp++; if (lw_valid !== m_valid || lw_addr !== m_addr || lw_data !== m_data || wr_count !== m_cnt) begin
        n_bad++; $display("[TB] FAIL rand_state[%0d] got v%b a%0d d%h c%0d want v%b a%0d d%h c%0d", i,
                          lw_valid, lw_addr, lw_data, wr_count, m_valid, m_addr, m_data, m_cnt);
      end
      n_cmp++; if (s_wr_count !== m_cnt[3:0]) begin
        n_bad++; $display("[TB] FAIL rand_cw4[%0d] got %0d want %0d", i, s_wr_count, m_cnt[3:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reg0();
    test_bypass();
    test_link();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/grf_writeback_sink.md
Name: grf_writeback_sink

Overview:
- General register file that consumes the write-back address/data produced by the WA/WD select stage, i.e. the receiving end of the write-back interface.
- Provides two combinational read ports to decode/ALU operand fetch.
- Performs write-first internal bypass so a same-cycle write is visible on the read ports.
- Exposes a last-write echo and an effective-write counter for debug/trace.

Parameters:
- DW, 32, data width of each register
- AW, 5, address width; depth = 2**AW registers, register 0 hardwired to zero
- CW, 32, width of effective-write counter

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- WE  input  1  write enable from control
- WA  input  AW  write address (RT / RD / 31 as selected upstream)
- WD  input  DW  write data (ALUOut / memory data / PC+8 as selected upstream)
- A1  input  AW  read address, port 1 (rs)
- A2  input  AW  read address, port 2 (rt)
- RD1  output  DW  read data, port 1
- RD2  output  DW  read data, port 2
- lw_valid  output  1  pulses high for one cycle after each effective write
- lw_addr  output  AW  address of last effective write
- lw_data  output  DW  data of last effective write
- wr_count  output  CW  number of effective writes since reset

Behaviour:
- One clock domain (clk). reset is asynchronous and active-high; the polarity and synchronicity are fixed.
- Storage: 2**AW registers of DW bits. Register 0 always reads 0 and is never written.
- Effective write: WE=1 and WA!=0, sampled at the rising edge of clk. It updates reg[WA]<=WD, lw_addr<=WA, lw_data<=WD, lw_valid<=1 and wr_count<=wr_count+1.
- wr_count wraps modulo 2**CW without saturation.
- Non-effective cycle (WE=0, or WA==0): no register changes, lw_valid<=0, lw_addr/lw_data/wr_count hold.
- Reads are combinational, with zero-cycle latency.
  - RD1 = 0 if A1==0.
  - Otherwise RD1 = WD if WE=1 and WA==A1 (write-first bypass).
  - Otherwise RD1 = reg[A1].
  - RD2 uses the same rule with A2.
- A1==A2 with bypass active: both ports return WD.
- WE=1, WA=0, A1=0: RD1=0 (bypass suppressed for register 0).
- Reset asserted (any time, including mid-write edge):
  - All registers, lw_addr, lw_data and wr_count go to 0 immediately; lw_valid goes to 0.
  - RD1/RD2 read 0 unless the bypass condition is active.
  - While reset is high, clock edges perform no writes.
  - The first edge after deassertion behaves normally.
- Reads take no clock edge and have no side effects on state.
- X on WE during reset is ignored; outside reset, WE must be 0/1.

Test Plan:
- Reset: assert reset mid-cycle after writing reg[5]=0x1234 -> immediately RD1(A1=5)=0, wr_count=0, lw_valid=0, lw_addr=0, lw_data=0.
- Basic write/read: WE=1, WA=8, WD=0xDEADBEEF, one edge, then WE=0, A1=8 -> RD1=0xDEADBEEF, lw_valid=1 for exactly one cycle, lw_addr=8, wr_count=1.
- Register 0 protection: WE=1, WA=0, WD=0xFFFFFFFF; A1=0 before and after the edge -> RD1=0 throughout, wr_count unchanged, lw_valid=0.
- Bypass: reg[3]=0x11; same cycle WE=1, WA=3, WD=0x22, A1=3, A2=3 -> RD1=RD2=0x22 before the edge, and still 0x22 after the edge with WE=0.
- Link write: WE=1, WA=31, WD=0x00003008 (PC+8), A2=31 -> RD2=0x00003008, lw_addr=31.
- Counter wrap: CW=4, perform 17 effective writes to alternating addresses 1/2 -> wr_count=1; interleaved WA=0 writes do not count.
